// File: rtl/mem_dump_reader_pkg.sv
// Shared types and default widths for the memory dump reader, the
// program-load writer and the word memory.
package mem_dump_reader_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/mem_dump_out_reg.sv
// Output holding register: captures a word on load and keeps it stable
// until the consumer accepts it.
module mem_dump_out_reg #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_addr  <= load_addr;
        end else if (out_valid && ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Sequential memory read-back engine streaming words on valid/ready.
// Optional checksum output enabled by defining MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int WAIT_W = $clog2(RD_LAT + 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cur_addr;
    logic [CNT_W-1:0]    remaining;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                accept;
    logic                capture;
    logic                handshake;

    assign accept    = (state == IDLE) && start;
    // Counter reaches 1 in the cycle the read data is valid.
    assign capture   = (state == WAIT) && (wait_cnt == WAIT_W'(1));
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (word_count == '0) ? DONE : READ;
            READ: state_nxt = WAIT;
            WAIT: if (capture) state_nxt = SEND;
            SEND: if (handshake) state_nxt = (remaining == CNT_W'(1)) ? DONE : READ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        busy        = (state != IDLE);
        done        = (state == DONE);
        if (state == READ) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = cur_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
        end else begin
            if (accept) begin
                cur_addr  <= base_addr;
                remaining <= word_count;
            end
            if (state == READ)
                wait_cnt <= WAIT_W'(RD_LAT);
            else if (state == WAIT)
                wait_cnt <= wait_cnt - WAIT_W'(1);
            if (handshake) begin
                remaining <= remaining - CNT_W'(1);
                cur_addr  <= cur_addr + ADDR_W'(1);
            end
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || accept)
            checksum <= '0;
        else if (handshake)
            checksum <= checksum ^ out_data;
    end
`endif

    mem_dump_out_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (capture),
        .load_data (mem_rd_data),
        .load_addr (cur_addr),
        .ready     (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr)
    );

endmodule
